// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction-fetch stage: PC, icache handshake, next-PC select
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic [31:0] icache_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_done,
  input  logic        PC_src,
  input  logic        jump,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign icache_addr = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign retired     = retired_q;
  assign icache_req  = req_q;
  assign instr_valid = valid_q;

  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump takes priority over a taken branch.
  always_comb begin
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (PC_src) begin
      next_pc = pc_plus4 + branch_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (icache_ready) begin
          instr_d = icache_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (instr_done) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          state_d   = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the upcoming state.
    req_d   = (state_d == REQ);
    valid_d = (state_d == EXEC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_ready = 1'b0;
  logic        instr_done = 1'b0;
  logic        PC_src = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] icache_rdata = 32'd0;
  logic        icache_req, instr_valid;
  logic [31:0] icache_addr, instr, pc, pc_plus4, retired;

  logic        hi_req, hi_valid;
  logic [31:0] hi_addr, hi_instr, hi_pc, hi_pc4, hi_ret;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_rdata(icache_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .instr_done(instr_done), .PC_src(PC_src), .jump(jump),
    .retired(retired)
  );

  fetch_unit #(.RESET_PC(32'h4000_0010)) u_hi (
    .clk(clk), .rst(rst),
    .icache_req(hi_req), .icache_addr(hi_addr),
    .icache_ready(1'b1), .icache_rdata(32'h0800_0040),
    .instr(hi_instr), .instr_valid(hi_valid),
    .pc(hi_pc), .pc_plus4(hi_pc4),
    .instr_done(1'b1), .PC_src(1'b1), .jump(1'b1),
    .retired(hi_ret)
  );

  typedef struct {
    logic [31:0] word;
    logic        j;
    logic        b;
    logic [31:0] next;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic j, input logic b);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (b) begin
      off = int'($signed(word[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  task automatic do_reset;
    icache_ready = 1'b0;
    instr_done   = 1'b0;
    jump         = 1'b0;
    PC_src       = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    exp_ret = 32'd0;
    @(negedge clk);
  endtask

  // Runs one instruction starting from a REQ cycle at cur_pc.
  task automatic exec_one(input logic [31:0] word, input logic j, input logic b,
                          input logic [31:0] cur_pc, input logic [31:0] exp_next,
                          input string name);
    chk({name, "_req_addr"}, icache_addr, cur_pc);
    icache_rdata = word;
    icache_ready = 1'b1;
    instr_done   = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
    chk({name, "_instr"}, instr, word);
    chk({name, "_pc"}, pc, cur_pc);
    icache_ready = 1'b0;
    instr_done   = 1'b1;
    jump         = j;
    PC_src       = b;
    @(negedge clk);
    exp_ret = exp_ret + 32'd1;
    chk({name, "_next_addr"}, icache_addr, exp_next);
    chk({name, "_req"}, 32'(icache_req), 32'd1);
    chk({name, "_retired"}, retired, exp_ret);
    instr_done = 1'b0;
    jump       = 1'b0;
    PC_src     = 1'b0;
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] m_pc, m_instr, m_ret;
    logic        m_exec;

    tbl[0] = '{32'h0000_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFC};
    tbl[1] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
    tbl[2] = '{32'h0000_0003, 1'b0, 1'b1, 32'h0000_0010};
    tbl[3] = '{32'h0000_0040, 1'b1, 1'b1, 32'h0000_0100};
    tbl[4] = '{32'h0000_FFFE, 1'b0, 1'b1, 32'h0000_00FC};
    tbl[5] = '{32'h1234_FFFE, 1'b0, 1'b0, 32'h0000_0100};
    tbl[6] = '{32'h03FF_FFFF, 1'b1, 1'b0, 32'h0FFF_FFFC};
    tbl[7] = '{32'h0000_0000, 1'b0, 1'b0, 32'h1000_0000};
    tbl[8] = '{32'h0000_0004, 1'b1, 1'b0, 32'h1000_0010};

    // Reset values, then free-running sequential fetch.
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(icache_req), 32'd0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_hi_pc", hi_pc, 32'h4000_0010);
    icache_ready = 1'b1;
    instr_done   = 1'b1;
    rst          = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("seq_req", 32'(icache_req), 32'd1);
        chk("seq_valid_low", 32'(instr_valid), 32'd0);
        chk("seq_addr", icache_addr, 32'(i * 2));
      end else begin
        chk("seq_valid", 32'(instr_valid), 32'd1);
        chk("seq_req_low", 32'(icache_req), 32'd0);
      end
      if (i == 0) chk("hi_first_addr", hi_addr, 32'h4000_0010);
      if (i == 2) chk("hi_jump_addr", hi_addr, 32'h4000_0100);
    end
    @(negedge clk);
    chk("seq_retired4", retired, 32'd4);
    chk("seq_addr_10", icache_addr, 32'h10);

    // Vector table: branches, jumps, priority and wrap.
    do_reset();
    cur = 32'h0;
    for (int i = 0; i < 9; i++) begin
      exec_one(tbl[i].word, tbl[i].j, tbl[i].b, cur, tbl[i].next, $sformatf("tbl%0d", i));
      cur = tbl[i].next;
    end

    // Cache miss at pc=8, then branch held off by instr_done=0.
    do_reset();
    exec_one(32'h1111_0000, 1'b0, 1'b0, 32'h0, 32'h4, "miss_pre0");
    exec_one(32'h1111_0000, 1'b0, 1'b0, 32'h4, 32'h8, "miss_pre1");
    icache_ready = 1'b0;
    icache_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      chk("miss_req", 32'(icache_req), 32'd1);
      chk("miss_addr", icache_addr, 32'h8);
      chk("miss_instr_held", instr, 32'h1111_0000);
      if (k < 5) @(negedge clk);
    end
    icache_rdata = 32'h1234_5678;
    icache_ready = 1'b1;
    @(negedge clk);
    chk("miss_valid", 32'(instr_valid), 32'd1);
    chk("miss_instr", instr, 32'h1234_5678);
    icache_ready = 1'b0;
    icache_rdata = 32'h0BAD_0BAD;
    PC_src       = 1'b1;
    instr_done   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_pc", pc, 32'h8);
      chk("hold_valid", 32'(instr_valid), 32'd1);
    end
    instr_done = 1'b1;
    @(negedge clk);
    chk("br_after_miss", icache_addr, 32'h0001_59EC);
    chk("br_after_miss_ret", retired, 32'd3);
    instr_done = 1'b0;
    PC_src     = 1'b0;

    // Asynchronous reset while executing at pc=0x20.
    do_reset();
    exec_one(32'h0000_0007, 1'b0, 1'b1, 32'h0, 32'h20, "ar_pre");
    icache_rdata = 32'hABCD_0000;
    icache_ready = 1'b1;
    @(negedge clk);
    chk("ar_valid_before", 32'(instr_valid), 32'd1);
    chk("ar_pc_before", pc, 32'h20);
    icache_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_pc", pc, 32'h0);
    chk("ar_req", 32'(icache_req), 32'd0);
    chk("ar_instr", instr, 32'h0);
    chk("ar_retired", retired, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_restart_req", 32'(icache_req), 32'd1);
    chk("ar_restart_addr", icache_addr, 32'h0);

    // Random stimulus against a transaction-level model.
    do_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_ret   = 32'h0;
    m_exec  = 1'b0;
    for (int c = 0; c < 600; c++) begin
      chk("rnd_req", 32'(icache_req), 32'(!m_exec));
      chk("rnd_valid", 32'(instr_valid), 32'(m_exec));
      chk("rnd_addr", icache_addr, m_pc);
      chk("rnd_pc4", pc_plus4, m_pc + 32'd4);
      chk("rnd_retired", retired, m_ret);
      if (m_exec) chk("rnd_instr", instr, m_instr);
      icache_ready = ($urandom_range(0, 2) != 0);
      instr_done   = ($urandom_range(0, 2) != 0);
      jump         = ($urandom_range(0, 3) == 0);
      PC_src       = $urandom_range(0, 1) == 1;
      icache_rdata = $urandom;
      if (!m_exec) begin
        if (icache_ready) begin
          m_instr = icache_rdata;
          m_exec  = 1'b1;
        end
      end else if (instr_done) begin
        m_pc   = ref_next(m_pc, m_instr, jump, PC_src);
        m_ret  = m_ret + 32'd1;
        m_exec = 1'b0;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core. Holds the program counter, fetches each instruction from the instruction cache over a request/ready handshake, and presents it to decode and `CONTROL_UNIT` with a valid flag. When the datapath signals the instruction is finished, it selects the next PC from `PC_src` and `jump` (produced by `CONTROL_UNIT`) and computes branch and jump targets internally from the held instruction.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `icache_req`  out  1  fetch request to the instruction cache.
- `icache_addr`  out  32  fetch address; equals `pc`.
- `icache_ready`  in  1  cache has valid `icache_rdata` this cycle.
- `icache_rdata`  in  32  fetched instruction word.
- `instr`  out  32  held instruction, to decode and control.
- `instr_valid`  out  1  `instr` is valid and executing.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  combinational `pc + 4`.
- `instr_done`  in  1  datapath has completed `instr`, including any data-cache stall.
- `PC_src`  in  1  branch taken, from `CONTROL_UNIT`.
- `jump`  in  1  jump, from `CONTROL_UNIT`.
- `retired`  out  32  count of completed instructions.

## Operation
- FSM states: IDLE, REQ, EXEC.
- IDLE: entered on reset. Moves to REQ unconditionally on the next edge.
- REQ:
  - `icache_req = 1` and `icache_addr = pc`, both held stable until `icache_ready`.
  - On an edge where `icache_ready = 1`: `instr <= icache_rdata`, then go to EXEC.
- EXEC:
  - `instr_valid = 1`; `instr` and `pc` are held.
  - On an edge where `instr_done = 1`: `pc <= next_pc`, `retired <= retired + 1`, then go to REQ.
- Next-PC selection, evaluated only in EXEC with `instr_done = 1`:
  - `jump = 1`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - `jump = 0`, `PC_src = 1`: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - Otherwise: `pc_plus4`.
  - If `jump` and `PC_src` are both 1, `jump` wins.
- Arithmetic is modulo 2^32. `pc = 32'hFFFF_FFFC` with a sequential next PC goes to `0`. `retired` wraps from `32'hFFFF_FFFF` to `0`.
- Ignored inputs:
  - `icache_ready` outside REQ.
  - `instr_done`, `PC_src` and `jump` outside EXEC.
- `icache_rdata` is sampled only on the accepting edge.

## Timing
- Reset values: `pc = RESET_PC`, `instr = 0`, `instr_valid = 0`, `icache_req = 0`, `retired = 0`, state IDLE.
- Reset is asynchronous: outputs take their reset values immediately on `rst` assertion, independent of `clk`.
- Reset mid-request or mid-execute:
  - `icache_req` and `instr_valid` drop immediately.
  - The pending fetch is abandoned; the cache must tolerate a withdrawn request.
- First `icache_req` goes high in the second cycle after `rst` deasserts (one cycle in IDLE).
- `icache_ready` may assert in the same cycle `icache_req` rises (a hit). `instr_valid` then rises the next cycle.
- The minimum is 2 cycles per instruction: 1 cycle in REQ, 1 cycle in EXEC.
- Each cycle of `icache_ready = 0` in REQ, or of `instr_done = 0` in EXEC, adds one cycle.
- All outputs are registered except `pc_plus4` and `icache_addr`, which are combinational from `pc`.
- `icache_req` and `instr_valid` are never both 1.

## Test plan
- **Reset and sequential fetch.** `RESET_PC = 0`, `icache_ready` tied 1, `instr_done` tied 1, `jump = PC_src = 0`.
  - Required: `icache_addr` sequence `0, 4, 8, C`.
  - Required: `instr_valid` pulses every 2nd cycle; `retired = 4` after the 4th EXEC edge.
- **Cache miss.** `icache_ready` held 0 for 5 cycles at `pc = 8`.
  - Required: `icache_req = 1` and `icache_addr = 8` stable for all 6 cycles.
  - Required: `instr` loads `icache_rdata` only on the ready edge.
- **Branch taken.** `pc = 32'h100`, `instr[15:0] = 16'hFFFE`, `PC_src = 1` with `instr_done`.
  - Required: next `icache_addr = 32'h0FC`.
  - Required: with `PC_src = 1` while `instr_done = 0`, the PC is unchanged.
- **Jump and priority.** `pc = 32'h4000_0010`, `instr[25:0] = 26'h0000040`, `jump = PC_src = 1`.
  - Required: next PC `32'h4000_0100`.
- **Wrap.** `RESET_PC = 32'hFFFF_FFFC`, one sequential instruction.
  - Required: next `icache_addr = 0`.
- **Async reset mid-EXEC.** Assert `rst` between clock edges while `instr_valid = 1` and `pc = 32'h20`.
  - Required: `instr_valid = 0` and `pc = RESET_PC` before the next edge.
  - Required: fetch restarts at `RESET_PC` after release.
